// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM encoding and default widths for the serial sequence generator and detector
package seq_pkg;
  localparam int MAX_LEN = 16;
  localparam int DIV_W   = 8;
  localparam int REP_W   = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    FIN   = 2'b11
  } state_e;
endpackage

// File: rtl/seq_bit_timer.sv
// seq_bit_timer: loadable bit-period down-counter flagging the first and last clock of each bit
module seq_bit_timer #(
  parameter int DIV_W = seq_pkg::DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             first_o,
  output logic             tc_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  assign first_o = en_i && cnt_q == period_i;
  assign tc_o    = en_i && cnt_q == '0;
  // count down while enabled, reloading the period at each bit end
  always_comb cnt_d = load_i ? period_i : en_i ? (tc_o ? period_i : cnt_q - DIV_W'(1)) : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sequence_generator_serial.sv
// sequence_generator_serial: shifts a captured pattern out MSB-first with programmable bit period and repeat count
module sequence_generator_serial
  import seq_pkg::*;
#(
  parameter int MAX_LEN = seq_pkg::MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int DIV_W   = seq_pkg::DIV_W,
  parameter int REP_W   = seq_pkg::REP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [DIV_W-1:0]   bit_period,
  input  logic [REP_W-1:0]   repeat_cnt,
  output logic               serial_out,
  output logic               bit_valid,
  output logic               bit_strobe,
  output logic               busy,
  output logic               done
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  state_e state_q, state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0] len_q, len_m1;
  logic [DIV_W-1:0] per_q;
  logic [REP_W-1:0] rep_q, rep_left_q, rep_left_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic serial_out_q, bit_valid_q, bit_strobe_q, busy_q, done_q;
  logic serial_out_d, bit_valid_d, bit_strobe_d, busy_d, done_d;
  logic accept, shift_go, first, tc;
  assign accept   = state_q == IDLE && start && !abort && len != '0;
  assign shift_go = state_q == SHIFT && !abort;
  assign len_m1   = len_q - LEN_W'(1);
  seq_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_q == LOAD),
    .en_i     (state_q == SHIFT),
    .period_i (per_q),
    .first_o  (first),
    .tc_o     (tc)
  );
  // next state, bit index and repeat bookkeeping
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    rep_left_d = rep_left_q;
    unique case (state_q)
      IDLE: state_d = accept ? LOAD : IDLE;
      LOAD: begin
        state_d    = abort ? IDLE : SHIFT;
        bit_idx_d  = len_m1[IDX_W-1:0];
        rep_left_d = rep_q;
      end
      SHIFT: begin
        if (abort) state_d = IDLE;
        else if (tc) begin
          if (bit_idx_q != '0) bit_idx_d = bit_idx_q - IDX_W'(1);
          else if (rep_left_q != '0) begin
            bit_idx_d  = len_m1[IDX_W-1:0];
            rep_left_d = rep_left_q - REP_W'(1);
          end else state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the current state and registered one cycle later
  always_comb begin
    serial_out_d = shift_go && pat_q[bit_idx_q];
    bit_valid_d  = shift_go;
    bit_strobe_d = shift_go && first;
    busy_d       = (state_q == LOAD || state_q == SHIFT) && !abort;
    done_d       = state_q == FIN;
  end
  // state, counters, shadow copies of the request and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pat_q        <= '0;
      len_q        <= '0;
      per_q        <= '0;
      rep_q        <= '0;
      bit_idx_q    <= '0;
      rep_left_q   <= '0;
      serial_out_q <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_strobe_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      rep_left_q   <= rep_left_d;
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      bit_strobe_q <= bit_strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      if (accept) begin
        pat_q <= pattern;
        len_q <= len > MAX_L ? MAX_L : len;
        per_q <= bit_period;
        rep_q <= repeat_cnt;
      end
    end
  end
  assign serial_out = serial_out_q;
  assign bit_valid  = bit_valid_q;
  assign bit_strobe = bit_strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_sequence_generator_serial.sv
// tb_sequence_generator_serial: random and directed stimulus checked against a per-cycle expected-output queue
module tb_sequence_generator_serial;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0] len = '0;
  logic [7:0] bit_period = '0;
  logic [7:0] repeat_cnt = '0;
  logic serial_out, bit_valid, bit_strobe, busy, done;
  logic [4:0] outs;
  logic [4:0] q[$];
  int errors = 0;
  int checks = 0;
  assign outs = {serial_out, bit_valid, bit_strobe, busy, done};
  always #5 clk = ~clk;
  sequence_generator_serial dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .len        (len),
    .bit_period (bit_period),
    .repeat_cnt (repeat_cnt),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .bit_strobe (bit_strobe),
    .busy       (busy),
    .done       (done)
  );
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s {serial,valid,strobe,busy,done} got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic st, input logic ab, input logic [15:0] pat, input logic [4:0] ln,
                     input logic [7:0] pr, input logic [7:0] rp);
    logic [4:0] e;
    int l, p, n, i;
    start = st;
    abort = ab;
    pattern = pat;
    len = ln;
    bit_period = pr;
    repeat_cnt = rp;
    @(posedge clk);
    #1;
    e = '0;
    if (q.size() != 0) begin
      if (ab && q[0] != 5'b00001) q.delete();
      else e = q.pop_front();
    end else if (st && !ab && ln != 0) begin
      l = ln > 16 ? 16 : int'(ln);
      p = int'(pr) + 1;
      n = l * p * (int'(rp) + 1);
      q.push_back(5'b00010);
      for (int k = 0; k < n; k++) begin
        i = l - 1 - ((k / p) % l);
        q.push_back({pat[i], 1'b1, k % p == 0, 1'b1, 1'b0});
      end
      q.push_back(5'b00001);
    end
    check($sformatf("out@%0t", $time), outs, e);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 16'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
  endtask
  initial begin
    #2;
    check("reset", outs, 5'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    cyc(1'b1, 1'b0, 16'h0005, 5'd3, 8'd0, 8'd0);
    idle(8);
    cyc(1'b1, 1'b0, 16'h0002, 5'd2, 8'd2, 8'd0);
    idle(10);
    cyc(1'b1, 1'b0, 16'h0005, 5'd3, 8'd0, 8'd2);
    idle(14);
    cyc(1'b1, 1'b0, 16'hFFFF, 5'd0, 8'd0, 8'd0);
    idle(4);
    cyc(1'b1, 1'b0, 16'h0005, 5'd3, 8'd1, 8'd1);
    idle(3);
    cyc(1'b1, 1'b0, 16'h0002, 5'd3, 8'd0, 8'd0);
    idle(16);
    cyc(1'b1, 1'b0, 16'h1234, 5'd20, 8'd0, 8'd0);
    idle(20);
    cyc(1'b1, 1'b0, 16'h00A5, 5'd8, 8'd0, 8'd0);
    idle(2);
    cyc(1'b0, 1'b1, 16'h00A5, 5'd8, 8'd0, 8'd0);
    cyc(1'b1, 1'b0, 16'h0033, 5'd6, 8'd1, 8'd0);
    idle(18);
    cyc(1'b1, 1'b1, 16'h00FF, 5'd8, 8'd0, 8'd0);
    idle(3);
    cyc(1'b1, 1'b0, 16'hF0F0, 5'd16, 8'd1, 8'd1);
    idle(10);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", outs, 5'b0);
    q.delete();
    @(posedge clk);
    #1;
    check("rst_hold", outs, 5'b0);
    reset = 1'b0;
    idle(5);
    cyc(1'b1, 1'b0, 16'h000B, 5'd4, 8'd0, 8'd0);
    idle(8);
    for (int c = 0; c < 3000; c++)
      cyc($urandom_range(3) == 0, $urandom_range(39) == 0, 16'($urandom),
          5'($urandom_range(20)), 8'($urandom_range(3)), 8'($urandom_range(3)));
    idle(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
